// File: rtl/sram_input_pio_pkg.sv
// Shared constants for the sram_input_pio input port: register addresses and reset defaults.
package sram_input_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RAW          = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd5;
    localparam logic [2:0] ADDR_DEB_LIMIT    = 3'd6;

    // 1 ms at 50 MHz; buttons are active-low, so falling edges are enabled by default.
    localparam logic [31:0] DEB_RESET_DEFAULT  = 32'd50000;
    localparam logic [31:0] RISE_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] FALL_RESET_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/sram_input_debounce.sv
// One input channel: two-flop synchroniser, saturating debounce counter and the
// debounced level with its one-cycle-delayed copy for edge detection.
module sram_input_debounce #(
    parameter int DEB_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit_i,
    input  logic [DEB_W-1:0] deb_limit_i,
    output logic             sync_o,
    output logic             stable_o,
    output logic             stable_d_o
);

    logic             d1_q, sync_q, stable_q, stable_dly_q;
    logic             stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            // ">=" rather than "==" so a limit lowered below the running count still fires.
            if (cnt_q >= deb_limit_i) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_q         <= 1'b0;
            sync_q       <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            d1_q         <= in_bit_i;
            sync_q       <= d1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign sync_o     = sync_q;
    assign stable_o   = stable_q;
    assign stable_d_o = stable_dly_q;

endmodule

// File: rtl/sram_input_pio.sv
// Avalon-MM input port: per-channel debounce, rise/fall edge capture with W1C,
// interrupt masking and a registered read mux.
module sram_input_pio
    import sram_input_pio_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               DEB_W      = 16,
    parameter logic [DEB_W-1:0] DEB_RESET  = DEB_W'(DEB_RESET_DEFAULT),
    parameter logic [WIDTH-1:0] RISE_RESET = WIDTH'(RISE_RESET_DEFAULT),
    parameter logic [WIDTH-1:0] FALL_RESET = WIDTH'(FALL_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync, stable, stable_dly;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [DEB_W-1:0] deb_limit_q, deb_limit_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] edge_set, w1c;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sram_input_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk        (clk),
            .reset      (reset),
            .in_bit_i   (in_port[i]),
            .deb_limit_i(deb_limit_q),
            .sync_o     (sync[i]),
            .stable_o   (stable[i]),
            .stable_d_o (stable_dly[i])
        );
    end

    assign wr_en    = chipselect & ~write_n;
    assign w1c      = (wr_en && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;
    assign edge_set = (stable & ~stable_dly & rise_en_q) | (~stable & stable_dly & fall_en_q);

    always_comb begin
        irq_mask_d  = irq_mask_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        deb_limit_d = deb_limit_q;
        // A new edge wins over a clear landing in the same cycle.
        edge_cap_d  = edge_set | (edge_cap_q & ~w1c);
        if (wr_en) begin
            case (address)
                ADDR_IRQ_MASK:  irq_mask_d  = writedata[WIDTH-1:0];
                ADDR_RISE_EN:   rise_en_d   = writedata[WIDTH-1:0];
                ADDR_FALL_EN:   fall_en_d   = writedata[WIDTH-1:0];
                ADDR_DEB_LIMIT: deb_limit_d = writedata[DEB_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:         readdata_d[WIDTH-1:0] = stable;
            ADDR_RAW:          readdata_d[WIDTH-1:0] = sync;
            ADDR_IRQ_MASK:     readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAPTURE: readdata_d[WIDTH-1:0] = edge_cap_q;
            ADDR_RISE_EN:      readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:      readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_DEB_LIMIT:    readdata_d[DEB_W-1:0] = deb_limit_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            rise_en_q   <= RISE_RESET;
            fall_en_q   <= FALL_RESET;
            deb_limit_q <= DEB_RESET;
            readdata_q  <= '0;
        end else begin
            irq_mask_q  <= irq_mask_d;
            edge_cap_q  <= edge_cap_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            deb_limit_q <= deb_limit_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
